// File: rtl/counter_display.sv
// counter_display: multi-digit up/down hex/BCD counter driving a multiplexed 7-segment display
// Ports:
//   CLK            system clock, all logic on posedge
//   RST_N          synchronous active-low reset
//   EN, UP_DN      count enable (sampled on step tick) and direction (1 = up)
//   BCD            1 = decimal digits 0-9, 0 = hex
//   LOAD, LOAD_VAL synchronous load strobe and value (wins over a step)
//   DP_MASK        decimal point per digit, 1 = lit
//   VALUE          current count, nibble k = digit k
//   WRAP           one-cycle pulse after a step that wraps around
//   DS_EN          active-low one-hot digit enables, blanked for one cycle per digit change
//   SEG            {A,B,C,D,E,F,G,DP}, active-high
// Build option: COUNTER_DISPLAY_LZB_EN enables leading-zero blanking.
module counter_display #(
    parameter int DIGITS      = 4,
    parameter int SCAN_PERIOD = 65536,
    parameter int STEP_PERIOD = 33554432
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                UP_DN,
    input  logic                BCD,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] LOAD_VAL,
    input  logic [DIGITS-1:0]   DP_MASK,
    output logic [4*DIGITS-1:0] VALUE,
    output logic                WRAP,
    output logic [DIGITS-1:0]   DS_EN,
    output logic [7:0]          SEG
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = $clog2(STEP_PERIOD);
    localparam int CW = $clog2(SCAN_PERIOD);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic [SW-1:0] step_cnt;
    logic [CW-1:0] scan_cnt;
    logic [IW-1:0] idx, idx_nxt;
    logic          step_tick, scan_tick, carry, blank;
    logic [W-1:0]  stepped, loaded;
    logic [3:0]    nib, d;

    assign step_tick = step_cnt == SW'(STEP_PERIOD - 1);
    assign scan_tick = scan_cnt == CW'(SCAN_PERIOD - 1);
    // The display register is loaded with the digit that will be current next cycle,
    // so SEG already shows the new digit during the blank cycle.
    assign idx_nxt = !scan_tick ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
    assign nib = VALUE[4*idx_nxt +: 4];

    always_comb begin
        stepped = VALUE;
        loaded  = LOAD_VAL;
        carry   = 1'b1;
        d       = '0;
        if (BCD) begin
            // Ripple carry/borrow digit by digit; carry ends high only on wrap-around.
            for (int k = 0; k < DIGITS; k++) begin
                d = VALUE[4*k +: 4];
                if (carry) begin
                    stepped[4*k +: 4] = UP_DN ? (d >= 4'd9 ? 4'd0 : d + 4'd1)
                                              : (d == 4'd0 ? 4'd9 : d > 4'd9 ? 4'd8 : d - 4'd1);
                    carry = UP_DN ? d >= 4'd9 : d == 4'd0;
                end
                loaded[4*k +: 4] = LOAD_VAL[4*k +: 4] > 4'd9 ? 4'd9 : LOAD_VAL[4*k +: 4];
            end
        end else begin
            stepped = UP_DN ? VALUE + W'(1) : VALUE - W'(1);
            carry   = UP_DN ? &VALUE : ~|VALUE;
        end
    end

`ifdef COUNTER_DISPLAY_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero;

    // lz[k] is set when digit k and every digit above it are zero.
    always_comb begin
        zero = 1'b1;
        lz   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero  = zero && VALUE[4*k +: 4] == 4'd0;
            lz[k] = zero;
        end
    end

    assign blank = idx_nxt != '0 && lz[idx_nxt];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            step_cnt <= '0;
            scan_cnt <= '0;
            idx      <= '0;
            VALUE    <= '0;
            WRAP     <= 1'b0;
            DS_EN    <= '1;
            SEG      <= '0;
        end else begin
            step_cnt <= step_tick ? '0 : step_cnt + SW'(1);
            scan_cnt <= scan_tick ? '0 : scan_cnt + CW'(1);
            idx      <= idx_nxt;
            VALUE    <= LOAD ? loaded : (step_tick && EN) ? stepped : VALUE;
            WRAP     <= !LOAD && step_tick && EN && carry;
            DS_EN    <= scan_tick ? '1 : ~(DIGITS'(1) << idx_nxt);
            SEG      <= {blank ? 7'd0 : GLYPH[nib], DP_MASK[idx_nxt]};
        end
    end
endmodule

// File: tb/tb_counter_display.sv
// tb_counter_display: randomized and directed checks of counter_display against a decimal/integer reference model
module tb_counter_display;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        UP_DN = 1'b1;
    logic        BCD = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_VAL = '0;
    logic [3:0]  DP_MASK = '0;
    logic [15:0] VALUE;
    logic        WRAP;
    logic [3:0]  DS_EN;
    logic [7:0]  SEG;
    logic [11:0] value3;
    logic        wrap3;
    logic [2:0]  ds3;
    logic [7:0]  seg3;

    localparam logic [6:0] GL [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    always #5 CLK = ~CLK;

    counter_display #(.DIGITS(4), .SCAN_PERIOD(4), .STEP_PERIOD(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP_DN(UP_DN), .BCD(BCD), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .DP_MASK(DP_MASK), .VALUE(VALUE), .WRAP(WRAP),
        .DS_EN(DS_EN), .SEG(SEG)
    );

    counter_display #(.DIGITS(3), .SCAN_PERIOD(4), .STEP_PERIOD(8)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP_DN(UP_DN), .BCD(BCD), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL[11:0]), .DP_MASK(DP_MASK[2:0]), .VALUE(value3), .WRAP(wrap3),
        .DS_EN(ds3), .SEG(seg3)
    );

    int n_chk = 0;
    int n_fail = 0;
    int t = 0;
    int m_val = 0;
    logic [15:0] e_val;
    logic        e_wrap;
    logic [3:0]  e_ds;
    logic [2:0]  e_ds3;
    logic [7:0]  e_seg;

    function automatic int to_dec(int v);
        int n = 0, p = 1;
        for (int k = 0; k < 4; k++) begin
            n += ((v >> (4 * k)) & 15) * p;
            p *= 10;
        end
        return n;
    endfunction

    function automatic int to_bcd(int n);
        int v = 0;
        for (int k = 0; k < 4; k++) begin
            v |= (n % 10) << (4 * k);
            n /= 10;
        end
        return v;
    endfunction

    // Advance one clock: predict outputs from the counting/scan rules, then sample #1 after the edge.
    task automatic step();
        int nt, ix, n;
        logic [3:0] nib;
        nt = t + 1;
        ix = (nt / 4) % 4;
        nib = 4'((m_val >> (4 * ix)) & 15);
        e_seg = {GL[nib], DP_MASK[ix]};
`ifdef COUNTER_DISPLAY_LZB_EN
        if (ix > 0 && (m_val >> (4 * ix)) == 0) e_seg[7:1] = '0;
`endif
        e_ds  = (nt % 4 == 0) ? 4'hF : ~(4'(1) << ix);
        e_ds3 = (nt % 4 == 0) ? 3'h7 : ~(3'(1) << ((nt / 4) % 3));
        e_wrap = 1'b0;
        if (LOAD) begin
            m_val = 0;
            for (int k = 0; k < 4; k++) begin
                n = (LOAD_VAL >> (4 * k)) & 15;
                if (BCD && n > 9) n = 9;
                m_val |= n << (4 * k);
            end
        end else if (t % 8 == 7 && EN) begin
            if (BCD) begin
                n = to_dec(m_val);
                e_wrap = UP_DN ? (n == 9999) : (n == 0);
                m_val = to_bcd(UP_DN ? (n + 1) % 10000 : (n + 9999) % 10000);
            end else begin
                e_wrap = UP_DN ? (m_val == 65535) : (m_val == 0);
                m_val = UP_DN ? (m_val + 1) % 65536 : (m_val + 65535) % 65536;
            end
        end
        e_val = 16'(m_val);
        @(posedge CLK);
        #1;
        t++;
    endtask

    // Step until just after the next step tick (exactly one tick consumed).
    task automatic run_to_tick();
        do step(); while (t % 8 != 0);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        LOAD = 1'b1;
        LOAD_VAL = 16'h1234;
        repeat (3) @(posedge CLK);
        #1;
        n_chk++;
        if (DS_EN !== 4'hF || SEG !== 8'h00 || VALUE !== 16'h0000 || WRAP !== 1'b0 || ds3 !== 3'h7) begin
            n_fail++;
            $display("FAIL reset: ds=%b seg=%h val=%h wrap=%b ds3=%b, want 1111 00 0000 0 111", DS_EN, SEG, VALUE, WRAP, ds3);
        end
        LOAD = 1'b0;
        RST_N = 1'b1;
        EN = 1'b1;
        UP_DN = 1'b1;
        BCD = 1'b0;
        t = 0;
        m_val = 0;
        repeat (7) step();
        n_chk++;
        if (VALUE !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_pre_tick: value=%h want 0000", VALUE);
        end
        step();
        n_chk++;
        if (VALUE !== 16'h0001 || VALUE !== e_val) begin
            n_fail++;
            $display("FAIL reset_first_tick: value=%h want 0001", VALUE);
        end
    endtask

    task automatic test_hex_wrap();
        BCD = 1'b0;
        UP_DN = 1'b1;
        EN = 1'b1;
        LOAD = 1'b1;
        LOAD_VAL = 16'hFFFE;
        step();
        LOAD = 1'b0;
        n_chk++;
        if (VALUE !== 16'hFFFE || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL hex_load: value=%h wrap=%b want fffe 0", VALUE, WRAP);
        end
        run_to_tick();
        n_chk++;
        if (VALUE !== 16'hFFFF || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL hex_ffff: value=%h wrap=%b want ffff 0", VALUE, WRAP);
        end
        run_to_tick();
        n_chk++;
        if (VALUE !== 16'h0000 || WRAP !== 1'b1) begin
            n_fail++;
            $display("FAIL hex_wrap: value=%h wrap=%b want 0000 1", VALUE, WRAP);
        end
        step();
        n_chk++;
        if (WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL hex_wrap_len: wrap=%b want 0", WRAP);
        end
    endtask

    task automatic test_bcd();
        BCD = 1'b1;
        UP_DN = 1'b0;
        EN = 1'b1;
        LOAD = 1'b1;
        LOAD_VAL = 16'h1000;
        step();
        LOAD = 1'b0;
        run_to_tick();
        n_chk++;
        if (VALUE !== 16'h0999 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL bcd_borrow: value=%h wrap=%b want 0999 0", VALUE, WRAP);
        end
        LOAD = 1'b1;
        LOAD_VAL = 16'h0000;
        step();
        LOAD = 1'b0;
        n_chk++;
        if (WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL bcd_load_nowrap: wrap=%b want 0", WRAP);
        end
        run_to_tick();
        n_chk++;
        if (VALUE !== 16'h9999 || WRAP !== 1'b1) begin
            n_fail++;
            $display("FAIL bcd_wrap: value=%h wrap=%b want 9999 1", VALUE, WRAP);
        end
        LOAD = 1'b1;
        LOAD_VAL = 16'h00A5;
        step();
        LOAD = 1'b0;
        n_chk++;
        if (VALUE !== 16'h0095 || VALUE !== e_val) begin
            n_fail++;
            $display("FAIL bcd_clamp: value=%h want 0095", VALUE);
        end
        UP_DN = 1'b1;
        LOAD = 1'b1;
        LOAD_VAL = 16'h0199;
        step();
        LOAD = 1'b0;
        run_to_tick();
        n_chk++;
        if (VALUE !== 16'h0200 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL bcd_carry: value=%h wrap=%b want 0200 0", VALUE, WRAP);
        end
    endtask

    task automatic test_priority();
        BCD = 1'b0;
        UP_DN = 1'b1;
        EN = 1'b1;
        while (t % 8 != 7) step();
        LOAD = 1'b1;
        LOAD_VAL = 16'h1234;
        step();
        LOAD = 1'b0;
        n_chk++;
        if (VALUE !== 16'h1234 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_load: value=%h wrap=%b want 1234 0", VALUE, WRAP);
        end
        LOAD = 1'b1;
        LOAD_VAL = 16'hFFFF;
        while (t % 8 != 7) step();
        step();
        LOAD = 1'b0;
        n_chk++;
        if (VALUE !== 16'hFFFF || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_nowrap: value=%h wrap=%b want ffff 0", VALUE, WRAP);
        end
        LOAD = 1'b1;
        LOAD_VAL = 16'h1234;
        step();
        LOAD = 1'b0;
        EN = 1'b0;
        repeat (40) step();
        n_chk++;
        if (VALUE !== 16'h1234 || WRAP !== 1'b0) begin
            n_fail++;
            $display("FAIL en_hold: value=%h wrap=%b want 1234 0", VALUE, WRAP);
        end
    endtask

    task automatic test_scan();
        logic [7:0] seg1;
`ifdef COUNTER_DISPLAY_LZB_EN
        seg1 = 8'h00;
`else
        seg1 = 8'hFC;
`endif
        EN = 1'b0;
        BCD = 1'b0;
        DP_MASK = 4'b0001;
        LOAD = 1'b1;
        LOAD_VAL = 16'h0008;
        step();
        LOAD = 1'b0;
        repeat (24) begin
            step();
            n_chk++;
            if (DS_EN !== e_ds || SEG !== e_seg || ds3 !== e_ds3) begin
                n_fail++;
                $display("FAIL scan t=%0d: ds=%b seg=%h ds3=%b want %b %h %b", t, DS_EN, SEG, ds3, e_ds, e_seg, e_ds3);
            end
            if (t % 16 == 0 || t % 16 == 1) begin
                n_chk++;
                if (DS_EN !== (t % 16 == 0 ? 4'b1111 : 4'b1110) || SEG !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL scan_d0 t=%0d: ds=%b seg=%h want seg ff", t, DS_EN, SEG);
                end
            end
            if (t % 16 == 4 || t % 16 == 5) begin
                n_chk++;
                if (DS_EN !== (t % 16 == 4 ? 4'b1111 : 4'b1101) || SEG !== seg1) begin
                    n_fail++;
                    $display("FAIL scan_d1 t=%0d: ds=%b seg=%h want seg %h", t, DS_EN, SEG, seg1);
                end
            end
            if (t % 12 == 9 || t % 12 == 1) begin
                n_chk++;
                if (ds3 !== (t % 12 == 9 ? 3'b011 : 3'b110)) begin
                    n_fail++;
                    $display("FAIL scan3_wrap t=%0d: ds3=%b", t, ds3);
                end
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            EN = $urandom_range(0, 3) != 0;
            UP_DN = $urandom_range(0, 1) == 1;
            DP_MASK = 4'($urandom);
            LOAD = $urandom_range(0, 9) == 0;
            LOAD_VAL = ($urandom_range(0, 3) == 0) ? (UP_DN ? 16'h9999 : 16'h0000) : 16'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                BCD = ~BCD;
                if (BCD) LOAD = 1'b1;
            end
            step();
            n_chk++;
            if (VALUE !== e_val || WRAP !== e_wrap || DS_EN !== e_ds || SEG !== e_seg || ds3 !== e_ds3) begin
                n_fail++;
                $display("FAIL random t=%0d: val=%h wrap=%b ds=%b seg=%h ds3=%b want %h %b %b %h %b",
                         t, VALUE, WRAP, DS_EN, SEG, ds3, e_val, e_wrap, e_ds, e_seg, e_ds3);
            end
        end
        LOAD = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hex_wrap();
        test_bcd();
        test_priority();
        test_scan();
        test_random();
        repeat (3) step();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
